register_pipe_arst: RTL and testbench

Parametrised elastic register pipeline: DEPTH stages of WIDTH-bit registers with per-stage valid bits, a valid/ready handshake on both sides, bubble collapsing, synchronous flush, and an occupancy count. It is the handshaked, multi-stage successor to the plain reset-value register. Typical uses are retiming long datapath routes and decoupling producer/consumer stalls between streaming blocks.

---
 rtl/register_pipe_arst.sv | 119 +++++++++++
 tb/tb_register_pipe_arst.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/register_pipe_arst.sv
// register_pipe_arst
//   Elastic register pipeline: DEPTH stages of WIDTH-bit data, each with its
//   own valid bit. Valid/ready handshake on both sides, empty stages collapse
//   (they load even while downstream stalls), synchronous flush, async reset.
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   flush     : drop all contents at the next edge; blocks both handshakes now
//   s_valid   : upstream word valid
//   s_ready   : pipeline can take s_data this cycle
//   s_data    : upstream word
//   m_valid   : output stage holds a word
//   m_ready   : downstream takes m_data this cycle
//   m_data    : output stage data (always driven)
//   occupancy : number of valid stages

// One pipeline stage: loads when the ready chain lets it advance.
module register_pipe_arst_stage #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             adv,
  input  logic             in_v,
  input  logic [WIDTH-1:0] in_d,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= 1'b0;
      d <= RESET_VAL;
    end else if (flush) begin
      v <= 1'b0;            // data kept, only validity dropped
    end else if (adv) begin
      v <= in_v;
      if (in_v) d <= in_d;  // a bubble moving in leaves old data in place
    end
  end

endmodule

module register_pipe_arst #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH-1:0]           s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [WIDTH-1:0]           m_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0]            rdy;
  logic [DEPTH-1:0]            in_v;
  logic [DEPTH-1:0][WIDTH-1:0] d;
  logic [DEPTH-1:0][WIDTH-1:0] in_d;

  // Ready ripples from the output back: a stage can load if it is empty or
  // everything ahead of it is moving. Evaluated in one block, output first.
  always_comb begin
    rdy = '0;
    rdy[DEPTH-1] = ~v[DEPTH-1] | m_ready;
    for (int i = DEPTH-2; i >= 0; i--)
      rdy[i] = ~v[i] | rdy[i+1];
  end

  assign s_ready = rdy[0] & ~flush & ~rst;

  always_comb begin
    in_v    = '0;
    in_d    = '0;
    in_v[0] = s_valid & s_ready;
    in_d[0] = s_data;
    for (int i = 1; i < DEPTH; i++) begin
      in_v[i] = v[i-1];
      in_d[i] = d[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    register_pipe_arst_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .adv   (rdy[g]),
      .in_v  (in_v[g]),
      .in_d  (in_d[g]),
      .v     (v[g]),
      .d     (d[g])
    );
  end

  assign m_valid = v[DEPTH-1] & ~flush;
  assign m_data  = d[DEPTH-1];

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++)
      occupancy = occupancy + OCC_W'(v[i]);
  end

endmodule

// File: tb/tb_register_pipe_arst.sv
module tb_register_pipe_arst;

  localparam int DEPTH = 3;

  logic       clk = 1'b0;
  logic       rst, flush, s_valid, m_ready;
  logic [7:0] s_data;
  logic       s_ready, m_valid;
  logic [7:0] m_data;
  logic [1:0] occupancy;

  register_pipe_arst #(.WIDTH(8), .DEPTH(DEPTH), .RESET_VAL(8'hA5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words in flight in arrival order, each with its stage
  // position. Every edge a word moves one stage closer to the output unless
  // it would collide with the word ahead of it.
  logic [7:0] mq_d[$];
  int         mq_p[$];
  int         cyc = 0, acc_cyc = -1, out_cyc = -1, recv = 0, max_occ = 0;
  logic       last_in_fire, last_out_fire;

  // Inputs already driven; check outputs mid-cycle, clock, update model.
  task automatic tick();
    logic p_sr, p_mv, inf, outf;
    int   lim, np;
    #1;
    p_sr = !rst && !flush && (mq_d.size() < DEPTH || m_ready);
    p_mv = !flush && mq_d.size() > 0 && mq_p[0] == DEPTH-1;
    check("s_ready", s_ready, p_sr);
    check("m_valid", m_valid, p_mv);
    check("occupancy", occupancy, mq_d.size());
    if (p_mv) check("m_data", m_data, mq_d[0]);
    if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
    inf  = s_valid && p_sr;
    outf = p_mv && m_ready;
    if (inf && s_data == 8'h01 && acc_cyc < 0) acc_cyc = cyc;
    if (p_mv && mq_d[0] == 8'h01 && out_cyc < 0) out_cyc = cyc;
    @(posedge clk);
    if (flush) begin
      mq_d.delete(); mq_p.delete();
    end else begin
      if (outf) begin
        void'(mq_d.pop_front()); void'(mq_p.pop_front());
        recv++;
      end
      lim = DEPTH-1;
      for (int k = 0; k < mq_p.size(); k++) begin
        np = (mq_p[k] + 1 > lim) ? lim : mq_p[k] + 1;
        mq_p[k] = np;
        lim = np - 1;
      end
      if (inf) begin
        mq_d.push_back(s_data); mq_p.push_back(0);
      end
    end
    last_in_fire  = inf;
    last_out_fire = outf;
    cyc++;
    #1;
  endtask

  typedef struct {
    logic sv; logic [7:0] sd; logic mr;
    logic exp_sr; logic exp_mv; logic [7:0] exp_md; int exp_occ;
  } vec_t;
  vec_t tbl[9];

  initial begin
    // fill and stall, then drain
    tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 0};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00, 1};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h00, 2};
    tbl[3] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h11, 3};
    tbl[4] = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 8'h11, 3};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 3};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 2};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 1};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0};

    // reset, checked before any clock edge
    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = 8'h00;
    #2;
    check("rst m_data", m_data, 8'hA5);
    check("rst m_valid", m_valid, 1'b0);
    check("rst occupancy", occupancy, 2'd0);
    check("rst s_ready", s_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst held s_ready", s_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("post-rst s_ready", s_ready, 1'b1);

    // latency and throughput
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_valid = 1'b1; s_data = 8'(i);
      tick();
    end
    s_valid = 1'b0;
    repeat (DEPTH + 1) tick();
    check("latency", out_cyc - acc_cyc, 3);
    check("stream recv", recv, 16);

    // fill and stall table
    for (int i = 0; i < 9; i++) begin
      s_valid = tbl[i].sv; s_data = tbl[i].sd; m_ready = tbl[i].mr;
      #1;
      check($sformatf("tbl%0d s_ready", i), s_ready, tbl[i].exp_sr);
      check($sformatf("tbl%0d m_valid", i), m_valid, tbl[i].exp_mv);
      check($sformatf("tbl%0d occ", i), occupancy, tbl[i].exp_occ);
      if (tbl[i].exp_mv) check($sformatf("tbl%0d m_data", i), m_data, tbl[i].exp_md);
      tick();
    end

    // flush with s_valid high on a full pipeline
    m_ready = 1'b0;
    foreach (tbl[i]) ; // keep table in scope
    s_valid = 1'b1; s_data = 8'hAA; tick();
    s_data = 8'hBB; tick();
    s_data = 8'hCC; tick();
    s_valid = 1'b0; tick();
    check("pre-flush occ", occupancy, 2'd3);
    flush = 1'b1; s_valid = 1'b1; s_data = 8'hEE;
    #1;
    check("flush m_valid", m_valid, 1'b0);
    check("flush s_ready", s_ready, 1'b0);
    tick();
    flush = 1'b0; s_valid = 1'b0;
    #1;
    check("post-flush occ", occupancy, 2'd0);
    m_ready = 1'b1; s_valid = 1'b1; s_data = 8'hDD; tick();
    s_valid = 1'b0;
    repeat (2) tick();
    check("after flush m_valid", m_valid, 1'b1);
    check("after flush m_data", m_data, 8'hDD);
    tick();

    // random backpressure, 1000 words
    begin
      int   sent = 0, guard = 0;
      logic pend = 1'b0;
      recv = 0; max_occ = 0;
      while ((sent < 1000 || mq_d.size() > 0) && guard < 20000) begin
        if (!pend && sent < 1000 && $urandom_range(0, 1) == 1) begin
          pend = 1'b1; s_data = 8'($urandom);
        end
        s_valid = pend;
        m_ready = ($urandom_range(0, 3) != 0);
        tick();
        if (last_in_fire) begin pend = 1'b0; sent++; end
        guard++;
      end
      s_valid = 1'b0;
      check("random sent", sent, 1000);
      check("random recv", recv, 1000);
      check("random max occ <= 3", max_occ <= 3, 1'b1);
    end

    // async reset with two words in flight
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'h5A; tick();
    s_data = 8'h6B; tick();
    s_valid = 1'b0;
    #1;
    check("pre-arst occ", occupancy, 2'd2);
    rst = 1'b1;
    #1;
    check("arst m_valid", m_valid, 1'b0);
    check("arst m_data", m_data, 8'hA5);
    check("arst occ", occupancy, 2'd0);
    check("arst s_ready", s_ready, 1'b0);
    mq_d.delete(); mq_p.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    m_ready = 1'b1;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
